demux_1xn_fifo: RTL and testbench
=================================

DEMUX_1XN_FIFO -- requirements
Module: demux_1xn_fifo

Interface
REQ-001 Parameter DATA_W, default 8: width of the data bus in bits.
REQ-002 Parameter N_CH, default 4: number of output channels (2..16).
REQ-003 Parameter DEPTH, default 4: entries per channel FIFO (power of two, >=2).
REQ-004 Parameter SEL_W, default $clog2(N_CH) (min 1): width of the select bus.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in  input  DATA_W  input data word.
REQ-008 validIn  input  1  input word valid.
REQ-009 select  input  SEL_W  destination channel index for the current input word.
REQ-010 readyIn  output  1  block can accept the current input word.
REQ-011 out  output  N_CH*DATA_W  flattened channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 validOut  output  N_CH  per-channel output valid.
REQ-013 readyOut  input  N_CH  per-channel downstream ready.
REQ-014 dropCount  output  8  saturating count of words dropped for out-of-range select.

Function
REQ-015 Input handshake: a word is accepted on a rising edge where validIn=1 and readyIn=1.
REQ-016 readyIn = 1 when select >= N_CH; otherwise readyIn = NOT full of channel select; readyIn is combinational from select and FIFO state only, never from validIn.
REQ-017 An accepted in-range word is written to the tail of FIFO[select]; a word with select >= N_CH is accepted, discarded and increments dropCount.
REQ-018 dropCount saturates at 255; no wrap.
REQ-019 validOut[k] = 1 exactly when FIFO[k] holds >=1 entry; out slice k = FIFO[k] head word, forced to 0 when empty.
REQ-020 Latency: a word accepted at edge t is visible on its channel after edge t (first cycle it can be consumed is t+1) when that FIFO was empty.
REQ-021 Output handshake: FIFO[k] head pops on an edge where validOut[k]=1 and readyOut[k]=1; readyOut[k] with FIFO empty has no effect.
REQ-022 Channels are independent; a stalled channel never blocks input to other channels.
REQ-023 Per-channel order is preserved (FIFO); no ordering relation between channels.
REQ-024 Push and pop on the same channel in the same edge: both occur, occupancy unchanged.
REQ-025 Full channel: readyIn=0 for that select even if a pop occurs in the same cycle (no pass-through); the word is not lost, upstream holds it.
REQ-026 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-027 validIn=0: no state change except pops.

Reset
REQ-028 While reset=1 at a rising edge: all pointers, occupancy counters and dropCount clear to 0.
REQ-029 During and after reset: validOut = 0, out = 0, readyIn = 1; FIFO storage contents need not be cleared.
REQ-030 Reset mid-operation discards all buffered words; any handshake in the reset cycle is ignored.

Structure
REQ-031 Shared package demux_pkg holds default parameter values (DATA_W, N_CH, DEPTH) and the dropCount width constant.
REQ-032 One sub-module demux_fifo (single-channel synchronous FIFO: push, pop, full, empty, head data), instantiated N_CH times via generate.
REQ-033 Top level contains only select decode, readyIn mux, drop counter and output flattening.

Verification
REQ-034 Reset, then in=8'hA5, select=2, validIn=1 for one cycle -> next cycle validOut=4'b0100, out[23:16]=8'hA5, all others 0.
REQ-035 readyOut[1]=0, push 5 words to channel 1 (DEPTH=4) -> first 4 accepted, readyIn=0 on 5th; pushes to channel 0 still accepted; releasing readyOut[1] yields words in order.
REQ-036 Channel 3 full, same cycle push to 3 and readyOut[3]=1 -> readyIn=0, one pop, occupancy 3; next cycle push accepted.
REQ-037 Channel 0 holding 2 words, simultaneous push and pop each cycle for 10 cycles -> occupancy stays 2, order preserved across pointer wrap.
REQ-038 N_CH=3, SEL_W=2, 300 words with select=3 -> readyIn=1 throughout, no validOut asserted, dropCount=255.
REQ-039 Fill channels 0 and 2, assert reset one cycle mid-traffic -> validOut=0, dropCount=0, readyIn=1 next cycle; subsequent push observed after 1-cycle latency.

Source files
------------

// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1-to-N demultiplexer with per-channel FIFOs:
// default parameter values, the drop counter width and its saturation value,
// and a helper that sizes the select bus from the channel count.
// ----------------------------------------------------------------------------
package demux_pkg;

    // Default geometry of the demultiplexer.
    localparam int DATA_W_DEF = 8;
    localparam int N_CH_DEF   = 4;
    localparam int DEPTH_DEF  = 4;

    // Drop counter width and the value it saturates at.
    localparam int               DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Width of the select bus: ceil(log2(n_ch)), never narrower than one bit.
    function automatic int sel_width(input int n_ch);
        if (n_ch <= 2) begin
            return 1;
        end else begin
            return $clog2(n_ch);
        end
    endfunction

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// ----------------------------------------------------------------------------
// demux_fifo
// Single-channel synchronous FIFO used once per demux output channel.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset (pointers and occupancy only)
//   push   : write wdata at the tail (ignored while full)
//   pop    : remove the head word (ignored while empty)
//   wdata  : word to write
//   full   : occupancy == DEPTH
//   empty  : occupancy == 0
//   rdata  : head word, forced to zero while empty
// ----------------------------------------------------------------------------
module demux_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rdata
);

    // Pointers wrap naturally because DEPTH is a power of two; the occupancy
    // counter needs one extra bit to represent the full state.
    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_eff_s;
    logic              pop_eff_s;

    // Status flags and qualified handshakes.
    always_comb begin
        full       = (count_r == CNT_W'(DEPTH));
        empty      = (count_r == {CNT_W{1'b0}});
        push_eff_s = push & ~full;
        pop_eff_s  = pop & ~empty;
    end

    // Storage array; contents are not cleared by reset, only pointers are.
    always_ff @(posedge clk) begin
        if (push_eff_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Write/read pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_eff_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head word, zeroed when nothing is buffered.
    always_comb begin
        if (empty) begin
            rdata = {DATA_W{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule : demux_fifo

// File: rtl/demux_1xn_fifo.sv
// ----------------------------------------------------------------------------
// demux_1xn_fifo
// Routes each input word to one of N_CH output channels, each buffered by its
// own FIFO so a stalled channel never blocks traffic to the others. Words
// addressed to a non-existent channel are accepted and discarded, and counted
// in a saturating drop counter.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   in        : input data word
//   validIn   : input word valid
//   select    : destination channel of the current word
//   readyIn   : current word can be accepted (never depends on validIn)
//   out       : flattened channel heads, channel k at [k*DATA_W +: DATA_W]
//   validOut  : per-channel head valid
//   readyOut  : per-channel downstream ready (pops the head)
//   dropCount : saturating count of words discarded for out-of-range select
// ----------------------------------------------------------------------------
module demux_1xn_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in,
    input  logic                   validIn,
    input  logic [SEL_W-1:0]       select,
    output logic                   readyIn,
    output logic [N_CH*DATA_W-1:0] out,
    output logic [N_CH-1:0]        validOut,
    input  logic [N_CH-1:0]        readyOut,
    output logic [DROP_W-1:0]      dropCount
);

    logic [N_CH-1:0]   sel_onehot_s;
    logic              sel_full_s;
    logic              in_range_s;
    logic [N_CH-1:0]   push_s;
    logic [N_CH-1:0]   full_s;
    logic [N_CH-1:0]   empty_s;
    logic [DATA_W-1:0] head_s [N_CH];
    logic [DROP_W-1:0] drop_r;

    // Select decode: one-hot channel and the full flag of the addressed
    // channel. An all-zero one-hot means select points past the last channel.
    always_comb begin
        sel_onehot_s = {N_CH{1'b0}};
        sel_full_s   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (select == SEL_W'(k)) begin
                sel_onehot_s[k] = 1'b1;
                sel_full_s      = full_s[k];
            end else begin
                sel_onehot_s[k] = 1'b0;
            end
        end
        in_range_s = |sel_onehot_s;
    end

    // Input ready and per-channel push. A full channel stays not-ready even if
    // it pops this cycle: there is no pass-through path.
    always_comb begin
        readyIn = reset | ~in_range_s | ~sel_full_s;
        if (validIn && !reset) begin
            push_s = sel_onehot_s & ~full_s;
        end else begin
            push_s = {N_CH{1'b0}};
        end
    end

    // Saturating count of discarded out-of-range words.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r <= {DROP_W{1'b0}};
        end else if (validIn && !in_range_s && (drop_r != DROP_MAX)) begin
            drop_r <= drop_r + DROP_W'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

    assign dropCount = drop_r;

    // One FIFO per channel plus output flattening. Outputs are held idle while
    // reset is asserted so nothing leaks before pointers are cleared.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        demux_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (push_s[k]),
            .pop    (readyOut[k]),
            .wdata  (in),
            .full   (full_s[k]),
            .empty  (empty_s[k]),
            .rdata  (head_s[k])
        );

        assign validOut[k]                 = ~reset & ~empty_s[k];
        assign out[k*DATA_W +: DATA_W]     = reset ? {DATA_W{1'b0}} : head_s[k];
    end

endmodule : demux_1xn_fifo

// File: tb/tb_demux_1xn_fifo.sv
// ----------------------------------------------------------------------------
// tb_demux_1xn_fifo
// Directed bench for demux_1xn_fifo. The main instance uses the default
// geometry (4 channels, depth 4); a second instance with 3 channels and a
// 2-bit select exercises out-of-range drops and counter saturation.
// ----------------------------------------------------------------------------
module tb_demux_1xn_fifo;

    logic        clk;
    logic        reset;

    // Main instance: N_CH=4, DEPTH=4, DATA_W=8.
    logic [7:0]  in;
    logic        valid_in;
    logic [1:0]  select;
    logic        ready_in;
    logic [31:0] out;
    logic [3:0]  valid_out;
    logic [3:0]  ready_out;
    logic [7:0]  drop_count;

    // Second instance: N_CH=3, SEL_W=2.
    logic [7:0]  in3;
    logic        valid_in3;
    logic [1:0]  select3;
    logic        ready_in3;
    logic [23:0] out3;
    logic [2:0]  valid_out3;
    logic [2:0]  ready_out3;
    logic [7:0]  drop_count3;

    int checks;
    int failures;

    demux_1xn_fifo #(.DATA_W(8), .N_CH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .validIn   (valid_in),
        .select    (select),
        .readyIn   (ready_in),
        .out       (out),
        .validOut  (valid_out),
        .readyOut  (ready_out),
        .dropCount (drop_count)
    );

    demux_1xn_fifo #(.DATA_W(8), .N_CH(3), .DEPTH(4), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in        (in3),
        .validIn   (valid_in3),
        .select    (select3),
        .readyIn   (ready_in3),
        .out       (out3),
        .validOut  (valid_out3),
        .readyOut  (ready_out3),
        .dropCount (drop_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (valid_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid_out: got %b expected %b", valid_out, 4'b0000);
        end
        checks++;
        if (out !== 32'h0) begin
            failures++;
            $display("FAIL reset_out: got %h expected %h", out, 32'h0);
        end
        checks++;
        if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_in: got %b expected 1", ready_in);
        end
        checks++;
        if (drop_count !== 8'd0 || drop_count3 !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop: got %0d/%0d expected 0/0", drop_count, drop_count3);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (valid_out !== 4'b0000 || ready_in !== 1'b1 || valid_out3 !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle: got vo=%b ri=%b vo3=%b expected 0000 1 000",
                     valid_out, ready_in, valid_out3);
        end
    endtask

    task automatic test_single();
        in       = 8'hA5;
        select   = 2'd2;
        valid_in = 1'b1;
        #1;
        checks++;
        if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b expected 1", ready_in);
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 4'b0100) begin
            failures++;
            $display("FAIL single_valid_out: got %b expected %b", valid_out, 4'b0100);
        end
        checks++;
        if (out !== 32'h00A5_0000) begin
            failures++;
            $display("FAIL single_out: got %h expected %h", out, 32'h00A5_0000);
        end
        ready_out = 4'b0100;
        tick();
        ready_out = 4'b0000;
        checks++;
        if (valid_out !== 4'b0000 || out !== 32'h0) begin
            failures++;
            $display("FAIL single_drained: got vo=%b out=%h expected 0000 0", valid_out, out);
        end
    endtask

    task automatic test_backpressure();
        ready_out = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            in       = 8'h10 + 8'(i);
            select   = 2'd1;
            valid_in = 1'b1;
            #1;
            checks++;
            if (ready_in !== (i < 4)) begin
                failures++;
                $display("FAIL bp_ready_push%0d: got %b expected %b", i, ready_in, (i < 4));
            end
            tick();
        end
        // A stalled channel 1 must not block channel 0.
        in     = 8'h77;
        select = 2'd0;
        #1;
        checks++;
        if (ready_in !== 1'b1) begin
            failures++;
            $display("FAIL bp_ch0_ready: got %b expected 1", ready_in);
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 4'b0011) begin
            failures++;
            $display("FAIL bp_valid_out: got %b expected %b", valid_out, 4'b0011);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out[15:8] !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL bp_order%0d: got %h expected %h", i, out[15:8], 8'h10 + 8'(i));
            end
            ready_out = 4'b0010;
            tick();
        end
        ready_out = 4'b0000;
        checks++;
        if (valid_out !== 4'b0001 || out[7:0] !== 8'h77) begin
            failures++;
            $display("FAIL bp_ch0_head: got vo=%b d=%h expected 0001 77", valid_out, out[7:0]);
        end
        ready_out = 4'b0001;
        tick();
        ready_out = 4'b0000;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            in       = 8'h30 + 8'(i);
            select   = 2'd3;
            valid_in = 1'b1;
            tick();
        end
        // Full channel with a pop this cycle: still not ready, one pop happens.
        in        = 8'h34;
        ready_out = 4'b1000;
        #1;
        checks++;
        if (ready_in !== 1'b0) begin
            failures++;
            $display("FAIL full_no_passthru: got %b expected 0", ready_in);
        end
        tick();
        ready_out = 4'b0000;
        checks++;
        if (ready_in !== 1'b1 || out[31:24] !== 8'h31) begin
            failures++;
            $display("FAIL full_after_pop: got ri=%b head=%h expected 1 31", ready_in, out[31:24]);
        end
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out[31:24] !== 8'h31 + 8'(i) || valid_out[3] !== 1'b1) begin
                failures++;
                $display("FAIL full_drain%0d: got %h v=%b expected %h 1",
                         i, out[31:24], valid_out[3], 8'h31 + 8'(i));
            end
            ready_out = 4'b1000;
            tick();
        end
        ready_out = 4'b0000;
        checks++;
        if (valid_out !== 4'b0000) begin
            failures++;
            $display("FAIL full_empty_after: got %b expected 0000", valid_out);
        end
    endtask

    task automatic test_wrap();
        select   = 2'd0;
        valid_in = 1'b1;
        in       = 8'h40;
        tick();
        in       = 8'h41;
        tick();
        for (int i = 0; i < 10; i++) begin
            in        = 8'h42 + 8'(i);
            ready_out = 4'b0001;
            #1;
            checks++;
            if (ready_in !== 1'b1 || out[7:0] !== 8'h40 + 8'(i)) begin
                failures++;
                $display("FAIL wrap_step%0d: got ri=%b head=%h expected 1 %h",
                         i, ready_in, out[7:0], 8'h40 + 8'(i));
            end
            tick();
        end
        valid_in  = 1'b0;
        ready_out = 4'b0000;
        // Occupancy stayed at two: exactly 4A and 4B remain.
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid_out[0] !== 1'b1 || out[7:0] !== 8'h4A + 8'(i)) begin
                failures++;
                $display("FAIL wrap_tail%0d: got v=%b d=%h expected 1 %h",
                         i, valid_out[0], out[7:0], 8'h4A + 8'(i));
            end
            ready_out = 4'b0001;
            tick();
        end
        ready_out = 4'b0000;
        checks++;
        if (valid_out !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_empty: got %b expected 0000", valid_out);
        end
    endtask

    task automatic test_drop();
        select3   = 2'd3;
        valid_in3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in3 = 8'(i);
            #1;
            checks++;
            if (ready_in3 !== 1'b1 || valid_out3 !== 3'b000 ||
                drop_count3 !== ((i > 255) ? 8'd255 : 8'(i))) begin
                failures++;
                $display("FAIL drop_step%0d: got ri=%b vo=%b cnt=%0d expected 1 000 %0d",
                         i, ready_in3, valid_out3, drop_count3, (i > 255) ? 255 : i);
            end
            tick();
        end
        checks++;
        if (drop_count3 !== 8'd255) begin
            failures++;
            $display("FAIL drop_saturate: got %0d expected 255", drop_count3);
        end
        select3 = 2'd2;
        in3     = 8'h99;
        tick();
        valid_in3 = 1'b0;
        checks++;
        if (valid_out3 !== 3'b100 || out3 !== 24'h99_0000 || drop_count3 !== 8'd255) begin
            failures++;
            $display("FAIL drop_inrange: got vo=%b out=%h cnt=%0d expected 100 990000 255",
                     valid_out3, out3, drop_count3);
        end
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            select = (i % 2 == 0) ? 2'd0 : 2'd2;
            in     = 8'h60 + 8'(i);
            tick();
        end
        checks++;
        if (valid_out !== 4'b0101) begin
            failures++;
            $display("FAIL mid_prefill: got %b expected 0101", valid_out);
        end
        // Handshakes during the reset cycle must be ignored.
        select    = 2'd0;
        in        = 8'hEE;
        ready_out = 4'b1111;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 4'b0000;
        #1;
        checks++;
        if (valid_out !== 4'b0000 || out !== 32'h0 || ready_in !== 1'b1) begin
            failures++;
            $display("FAIL mid_cleared: got vo=%b out=%h ri=%b expected 0000 0 1",
                     valid_out, out, ready_in);
        end
        checks++;
        if (drop_count !== 8'd0 || drop_count3 !== 8'd0 || valid_out3 !== 3'b000) begin
            failures++;
            $display("FAIL mid_drop_cleared: got %0d/%0d vo3=%b expected 0/0 000",
                     drop_count, drop_count3, valid_out3);
        end
        select   = 2'd1;
        in       = 8'h55;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 4'b0010 || out !== 32'h0000_5500) begin
            failures++;
            $display("FAIL mid_repush: got vo=%b out=%h expected 0010 00005500", valid_out, out);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        in         = 8'h00;
        valid_in   = 1'b0;
        select     = 2'd0;
        ready_out  = 4'b0000;
        in3        = 8'h00;
        valid_in3  = 1'b0;
        select3    = 2'd0;
        ready_out3 = 3'b000;
        #2;
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1xn_fifo
